// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// the row/column to keycode map and the named operator keycodes.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] KC_CLEAR = 4'd10;
    localparam logic [3:0] KC_EXEC  = 4'd11;
    localparam logic [3:0] KC_DIV   = 4'd12;
    localparam logic [3:0] KC_MUL   = 4'd13;
    localparam logic [3:0] KC_SUB   = 4'd14;
    localparam logic [3:0] KC_ADD   = 4'd15;

    // Indexed by 4*row + col; entry 0 is the rightmost element.
    localparam logic [15:0][3:0] KEYMAP = {
        KC_DIV, KC_EXEC, 4'd0,   KC_CLEAR,
        KC_MUL, 4'd9,    4'd8,   4'd7,
        KC_SUB, 4'd6,    4'd5,   4'd4,
        KC_ADD, 4'd3,    4'd2,   4'd1
    };

    function automatic logic [3:0] keymap_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEYMAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Key event bus from the scanner to the key decoder, plus FSM debug state.
interface keypad_if;

    // keystrobe is a valid pulse with no ready: the consumer must take
    // keycode in the strobe cycle; keycode then holds until the next strobe.
    logic                  keystrobe;
    logic [3:0]            keycode;
    logic                  key_down;
    keypad_pkg::state_t    state;

    modport master (output keystrobe, output keycode, output key_down, output state);
    modport slave  (input  keystrobe, input  keycode, input  key_down, input  state);

endinterface

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer; resets to all ones so idle
// pulled-up inputs read inactive out of reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and one strobe per press.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key is held.
module keypad_scanner import keypad_pkg::*; #(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    keypad_if.master   kp
);

    localparam int BASE_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_MAX  = (BASE_MAX > REP_MAX) ? BASE_MAX : REP_MAX;
`else
    localparam int CNT_MAX  = BASE_MAX;
`endif
    localparam int CNT_W    = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    if (SCAN_DIV < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("keypad_scanner: parameter out of range");
    end

    state_t           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic             strobe_q, strobe_d;
    logic [1:0]       col_p1, col_p2;
    logic [3:0]       row_s;
    logic [1:0]       hit_row;
    logic             any_low;
    logic             row_low;
    logic             settled;
`ifdef KEYPAD_REPEAT_EN
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             rep_on_q, rep_on_d;
`endif

    sync2 #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (row_s)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // row_s lags col_n by the synchronizer depth; col_p2 is the column that
    // was driven when the current row_s value was captured at the pins.
    assign settled = (col_p2 == col_q);
    assign row_low = ~row_s[row_q];
    assign any_low = ~&row_s;

    always_comb begin
        hit_row = 2'd3;
        if      (!row_s[0]) hit_row = 2'd0;
        else if (!row_s[1]) hit_row = 2'd1;
        else if (!row_s[2]) hit_row = 2'd2;
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        strobe_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d    = rep_q;
        rep_on_d = rep_on_q;
`endif
        unique case (state_q)
            ST_SCAN: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (any_low) begin
                        // Credit the hit to the column that produced it and park there.
                        row_d   = hit_row;
                        col_d   = col_p2;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_DEBOUNCE: begin
                if (settled) begin
                    if (row_low) begin
                        if (cnt_q == DEB_LAST) begin
                            strobe_d = 1'b1;
                            code_d   = keymap_lookup(row_q, col_q);
                            cnt_d    = '0;
                            state_d  = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d    = '0;
                            rep_on_d = 1'b0;
`endif
                        end else begin
                            cnt_d = sat_inc(cnt_q);
                        end
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_q + 2'd1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_HELD: begin
                if (!row_low) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (rep_q == (rep_on_q ? PER_LAST : DLY_LAST)) begin
                    strobe_d = 1'b1;
                    rep_d    = '0;
                    rep_on_d = 1'b1;
                end else begin
                    rep_d = sat_inc(rep_q);
                end
`endif
            end
            ST_RELEASE: begin
                if (row_low) begin
                    cnt_d   = '0;
                    state_d = ST_HELD;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = ST_SCAN;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SCAN;
            col_q    <= 2'd0;
            row_q    <= 2'd0;
            cnt_q    <= '0;
            code_q   <= 4'h0;
            strobe_q <= 1'b0;
            col_p1   <= 2'd0;
            col_p2   <= 2'd0;
`ifdef KEYPAD_REPEAT_EN
            rep_q    <= '0;
            rep_on_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
            col_p1   <= col_q;
            col_p2   <= col_p1;
`ifdef KEYPAD_REPEAT_EN
            rep_q    <= rep_d;
            rep_on_q <= rep_on_d;
`endif
        end
    end

    assign col_n        = ~(4'b0001 << col_q);
    assign kp.keystrobe = strobe_q;
    assign kp.keycode   = code_q;
    assign kp.key_down  = (state_q == ST_HELD) || (state_q == ST_RELEASE);
    assign kp.state     = state_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 Parameter SCAN_DIV, 16, clock cycles each column is driven before advancing (>=2).
REQ-003 Parameter DEBOUNCE_CYCLES, 50000, consecutive stable cycles to accept press or release (>=2).
REQ-004 Parameter REPEAT_DELAY, 25000000, held cycles before first auto-repeat (used only with KEYPAD_REPEAT_EN).
REQ-005 Parameter REPEAT_PERIOD, 5000000, cycles between auto-repeat strobes (used only with KEYPAD_REPEAT_EN).
REQ-006 Port clk  input  1  system clock, all logic rising-edge.
REQ-007 Port rst_n  input  1  asynchronous active-low reset.
REQ-008 Port row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-009 Port col_n  output  4  keypad column drive, active-low one-hot.
REQ-010 Port keystrobe  output  1  one-cycle pulse per accepted key; feeds the key decoder.
REQ-011 Port keycode  output  4  code of last accepted key, valid from the keystrobe cycle until the next one.
REQ-012 Port key_down  output  1  high while an accepted key is held (HELD or RELEASE state).

Function
REQ-013 row_n SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-014 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: drive col_n low on column c for SCAN_DIV cycles, then c advances 0->1->2->3->0; rows sampled only on the last cycle of each slot.
REQ-016 SCAN: sampled row low -> latch (row r, column c), freeze col_n, clear counter, enter DEBOUNCE; several rows low -> lowest r wins.
REQ-017 DEBOUNCE: latched row low -> counter increments; latched row high -> return to SCAN at column c+1, no strobe.
REQ-018 DEBOUNCE: counter reaching DEBOUNCE_CYCLES -> keystrobe high for exactly one cycle, keycode updated in the same cycle, enter HELD.
REQ-019 keycode SHALL equal KEYMAP[4*r+c]: row0 1,2,3,15(+); row1 4,5,6,14(-); row2 7,8,9,13(*); row3 10(clear),0,11(=),12(/).
REQ-020 HELD: col_n frozen, other keys ignored; latched row high -> clear counter, enter RELEASE.
REQ-021 RELEASE: row high for DEBOUNCE_CYCLES consecutive cycles -> SCAN at column c+1; row low again -> HELD with no new strobe.
REQ-022 Counters SHALL saturate, never wrap; width is clog2 of the largest parameter in use.
REQ-023 At most one keystrobe per press-release cycle unless KEYPAD_REPEAT_EN is defined.

Reset
REQ-024 rst_n low SHALL immediately force state SCAN, col_n=4'b1110, column index 0, all counters 0, keystrobe 0, keycode 4'h0, key_down 0, synchronizer flops 1.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL discard the pending key with no strobe.

Configuration
REQ-026 Macro KEYPAD_REPEAT_EN defined: in HELD, after REPEAT_DELAY cycles a further keystrobe with the same keycode, then one every REPEAT_PERIOD cycles until release.
REQ-027 Macro KEYPAD_REPEAT_EN undefined: no repeat counter logic is synthesized and REQ-023 holds unconditionally.

Structure
REQ-028 Package keypad_pkg SHALL hold the state enum, the 16-entry KEYMAP constant, and named keycode constants KC_CLEAR=10, KC_EXEC=11, KC_DIV=12, KC_MUL=13, KC_SUB=14, KC_ADD=15.
REQ-029 Sub-module sync2 (parameterized-width 2-flop synchronizer, async active-low reset to 1) SHALL be instantiated for row_n.

Verification (bench: SCAN_DIV=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-030 Hold row1/col2 low 40 cycles then release -> exactly one keystrobe, keycode=6, key_down high until release debounced.
REQ-031 Press row3/col0 glitch of 2 cycles -> no keystrobe, scan resumes at column 1.
REQ-032 Press row0/col3, bounce release high 2 cycles then low, then release cleanly -> single keystrobe keycode=15.
REQ-033 Hold row2/col1 and row3/col1 simultaneously -> keycode=8; while held press row0/col0 -> ignored.
REQ-034 Assert rst_n during DEBOUNCE of row3/col2 -> no strobe, col_n=4'b1110, keycode=0 immediately.
REQ-035 With KEYPAD_REPEAT_EN, hold row1/col0 60 cycles -> strobes at accept, +20, +28, +36..., all keycode=4.
